imem_fetch_ctrl: RTL

//  Instruction-fetch sequencer for the 64x32 combinational-read instruction memory.

---
 rtl/imem_fetch_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch sequencer for a combinational-read instruction memory.
// It owns the program counter, drives the memory address and registers each
// fetched word. Words go to decode over a valid/ready handshake. A branch
// redirect flushes the held word, and the block halts at the end of the program.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start            pulse; begins fetching at address 0 from IDLE or HALT
//   imem_addr        memory address (this is the pc register)
//   imem_rdata       combinational read data for imem_addr
//   inst_out/inst_pc registered instruction and the address it came from
//   inst_valid       inst_out/inst_pc hold a word for decode
//   inst_ready       decode accepts the word
//   redirect_valid   branch taken: flush and refetch from redirect_target
//   redirect_target  new fetch address
//   halted           program finished
//   redirect_err     sticky; a redirect pointed past LAST_ADDR
//   fetch_count      handshakes completed since start (saturating)
//   fsm_state        current FSM state for observation
//
// Handshake: a word transfers on every rising edge where inst_valid and
// inst_ready are both 1. Once inst_valid is raised, inst_out and inst_pc stay
// stable until that transfer happens or a redirect flushes the word.
`timescale 1ns/1ps
module imem_fetch_ctrl #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter int                LAST_ADDR = 63,
    parameter logic [DATA_W-1:0] HALT_WORD = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              halted,
    output logic              redirect_err,
    output logic [CNT_W-1:0]  fetch_count,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(LAST_ADDR);
    // One extra bit so a target above LAST_ADDR is detectable at any width.
    localparam logic [ADDR_W:0]   LAST_EXT = (ADDR_W+1)'(LAST_ADDR);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              hs;
    logic              cap;
    logic              bad_target;

    assign hs         = inst_valid & inst_ready;
    // The output slot can take a new word when it is empty or being emptied.
    assign cap        = !inst_valid | inst_ready;
    assign bad_target = {1'b0, redirect_target} > LAST_EXT;
    assign imem_addr  = pc;
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            inst_out     <= '0;
            inst_pc      <= '0;
            inst_valid   <= 1'b0;
            halted       <= 1'b0;
            redirect_err <= 1'b0;
            fetch_count  <= '0;
        end else begin
            // A word taken by decode counts even if a redirect arrives in the
            // same cycle. The start branch below overrides this with a clear.
            if (hs && (fetch_count != '1)) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end

            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state        <= RUN;
                        pc           <= '0;
                        fetch_count  <= '0;
                        redirect_err <= 1'b0;
                        halted       <= 1'b0;
                    end
                end

                RUN, DRAIN: begin
                    if (redirect_valid) begin
                        inst_valid <= 1'b0;
                        if (bad_target) begin
                            redirect_err <= 1'b1;
                            halted       <= 1'b1;
                            state        <= HALT;
                        end else begin
                            pc    <= redirect_target;
                            state <= RUN;
                        end
                    end else if (state == RUN) begin
                        if (cap) begin
                            if (imem_rdata == HALT_WORD) begin
                                // The end marker is never handed to decode.
                                inst_valid <= 1'b0;
                                state      <= DRAIN;
                            end else begin
                                inst_out   <= imem_rdata;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                // pc stays on the last address, so it never wraps.
                                if (pc == LAST_PC) begin
                                    state <= DRAIN;
                                end else begin
                                    pc <= pc + ADDR_W'(1);
                                end
                            end
                        end
                    end else begin
                        // DRAIN: wait until the last word has been taken.
                        if (!inst_valid || hs) begin
                            inst_valid <= 1'b0;
                            halted     <= 1'b1;
                            state      <= HALT;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
